shared_mem_responder: RTL and testbench
=======================================

Name: shared_mem_responder

Overview:
- Memory-side responder for the FPGA user controller's request interface (rd_req / fpga_wr_en / req_addr / write_data / flag_we / out_flag / in_flag).
- Owns the single-port synchronous frame SRAM and the host/FPGA handshake flag word.
- Arbitrates SRAM access between the PCI host port, which has priority and cannot be stalled, and FPGA-side requests.
- Returns FPGA read data with rd_ready and PCI read data with pci_rd_valid.

Parameters:
- ADDR_W, 21, word address width.
- DATA_W, 32, data width.
- FLAG_ADDR, 21'h07FFFE, word address of the flag register.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- pci_wr_en  input  1  host write strobe, one word per cycle
- pci_rd_en  input  1  host read strobe
- pci_req_addr  input  ADDR_W  host word address
- pci_input_data  input  DATA_W  host write data
- pci_rd_data  output  DATA_W  host read data
- pci_rd_valid  output  1  host read data valid, one-cycle pulse
- rd_req  input  1  FPGA read request, one-cycle pulse
- fpga_wr_en  input  1  FPGA write request, one-cycle pulse
- req_addr  input  ADDR_W  FPGA word address
- write_data  input  DATA_W  FPGA write data
- rd_data  output  DATA_W  FPGA read data
- rd_ready  output  1  FPGA read data valid, one-cycle pulse
- flag_we  input  1  FPGA flag write, address-independent
- out_flag  input  DATA_W  FPGA flag write value
- in_flag  output  DATA_W  current flag register value
- mem_en, mem_we  output  1 each  SRAM enable and write enable
- mem_addr  output  ADDR_W  SRAM address
- mem_wdata  output  DATA_W  SRAM write data
- mem_rdata  input  DATA_W  SRAM read data, valid the cycle after mem_en with mem_we low
- req_overflow  output  1  sticky: FPGA request arrived while the pending buffer was full
- pci_collision  output  1  sticky: pci_wr_en and pci_rd_en asserted in the same cycle

Behaviour:
- Reset:
  - All outputs 0, flag register 0, pending buffer empty, sticky errors cleared.
  - Reset mid-operation drops any pending or in-flight access; no rd_ready or pci_rd_valid pulse follows.
- Flag register:
  - Any access whose address equals FLAG_ADDR goes to the flag register, never to the SRAM.
  - flag_we loads out_flag regardless of req_addr.
  - A PCI write to FLAG_ADDR loads pci_input_data.
  - If both happen in the same cycle, the PCI write wins.
  - in_flag is driven by the register, so a write is visible the cycle after the write edge.
- PCI port:
  - Serviced in the cycle it is asserted; drives mem_* combinationally from the PCI inputs.
  - pci_rd_valid and pci_rd_data are registered, asserted exactly 2 cycles after the pci_rd_en cycle. A FLAG_ADDR read returns the flag with the same latency.
  - If pci_wr_en and pci_rd_en are both high, the write is performed, the read is dropped, and pci_collision is set.
- FPGA port:
  - rd_req or fpga_wr_en is captured into a one-entry pending buffer at the clock edge (fields: op, addr, data).
  - If both are high, the write takes precedence and req_overflow is set.
  - The pending entry issues to the SRAM in any cycle with no PCI access, then the buffer empties.
  - Back-to-back requests are sustained: a request arriving in the cycle the buffer issues is accepted.
  - A request arriving while the buffer is held and not issuing is dropped and req_overflow is set.
- Pending-buffer FSM:
  - EMPTY -> HELD on a request.
  - HELD -> EMPTY on issue with no new request.
  - HELD -> HELD on issue with a new request, or on PCI stall.
- FPGA read latency:
  - No contention: rd_ready is asserted 3 cycles after the request cycle (capture, issue, SRAM, register).
  - Each PCI-occupied cycle while the entry is HELD adds 1 cycle.
  - rd_data holds its value until the next rd_ready.
  - FLAG_ADDR reads return the flag with the same timing.
- Ordering:
  - FPGA accesses complete in order.
  - A PCI write to the same address in the same cycle an FPGA write is pending leaves the FPGA value last, because the FPGA write issues later.
- No address wrap: addresses are used as-is, and FLAG_ADDR is excluded from the SRAM map.

Decomposition:
- shared_mem_pkg: FLAG_ADDR, ADDR_W, DATA_W, and the flag command constants (32'h0001_0000 start, 32'h0000_0002 ack, 32'h0000_0004 done).
- The same package holds the typedef for the pending-request struct {op, addr, data} and the enum {EMPTY, HELD}.
- One sub-module, fpga_req_buffer, holds the pending-request register and its FSM.

Test Plan:
- PCI write 0xDEADBEEF to addr 0x00010, then PCI read of 0x00010 -> pci_rd_valid 2 cycles later with 0xDEADBEEF.
- FPGA rd_req at addr 0x00010, idle PCI -> rd_ready 3 cycles later, rd_data 0xDEADBEEF, a single-cycle pulse.
- FPGA rd_req while PCI writes on 2 consecutive cycles -> rd_ready delayed to 5 cycles; mem_* shows PCI accesses first.
- PCI write 0x0001_0000 to FLAG_ADDR -> in_flag 0x0001_0000 next cycle. Then flag_we with 0x2 and a PCI flag write of 0x5 in the same cycle -> in_flag 0x5.
- Two FPGA requests while the PCI port is busy every cycle -> second request dropped, req_overflow = 1 until reset.
- Assert rst_n low one cycle after an FPGA rd_req -> no rd_ready, all outputs 0, and in_flag 0 after release.

Source files
------------

// File: rtl/shared_mem_pkg.sv
// Shared definitions for the frame-SRAM responder: geometry, flag commands,
// pending-request record and pending-buffer state encoding.
package shared_mem_pkg;

  localparam int ADDR_W = 21;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] FLAG_ADDR = 21'h07FFFE;

  // Host/FPGA handshake words exchanged through the flag register
  localparam logic [DATA_W-1:0] FLAG_CMD_START = 32'h0001_0000;
  localparam logic [DATA_W-1:0] FLAG_CMD_ACK   = 32'h0000_0002;
  localparam logic [DATA_W-1:0] FLAG_CMD_DONE  = 32'h0000_0004;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } req_op_e;

  typedef struct packed {
    req_op_e             op;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   data;
  } req_t;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/fpga_req_buffer.sv
// One-entry holding register for FPGA-side requests; the entry waits out
// host-port traffic and is released on the first idle SRAM cycle.
module fpga_req_buffer
  import shared_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  input  logic              stall,
  output logic              issue,
  output req_t              entry,
  output logic              overflow
);

  buf_state_e state, state_nx;
  req_t       entry_nx;
  logic       new_req;
  logic       accept;
  logic       drop;

  always_comb begin
    new_req  = rd_req | wr_req;
    issue    = (state == HELD) && !stall;
    // The slot frees in the same cycle it issues, so a new request can refill it
    accept   = new_req && ((state == EMPTY) || issue);
    drop     = (rd_req && wr_req) || (new_req && !accept);
    state_nx = state;
    entry_nx = entry;

    case (state)
      EMPTY:   if (accept) state_nx = HELD;
      HELD:    if (issue && !accept) state_nx = EMPTY;
      default: state_nx = EMPTY;
    endcase

    if (accept) begin
      entry_nx.op   = wr_req ? OP_WRITE : OP_READ;
      entry_nx.addr = req_addr;
      entry_nx.data = req_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= EMPTY;
      entry    <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      entry <= entry_nx;
      if (drop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Memory-side responder: owns the frame SRAM port and the handshake flag word,
// giving the host port priority and queueing FPGA requests behind it.
module shared_mem_responder #(
  parameter int                ADDR_W    = shared_mem_pkg::ADDR_W,
  parameter int                DATA_W    = shared_mem_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] FLAG_ADDR = shared_mem_pkg::FLAG_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pci_wr_en,
  input  logic              pci_rd_en,
  input  logic [ADDR_W-1:0] pci_req_addr,
  input  logic [DATA_W-1:0] pci_input_data,
  output logic [DATA_W-1:0] pci_rd_data,
  output logic              pci_rd_valid,
  input  logic              rd_req,
  input  logic              fpga_wr_en,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ready,
  input  logic              flag_we,
  input  logic [DATA_W-1:0] out_flag,
  output logic [DATA_W-1:0] in_flag,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              req_overflow,
  output logic              pci_collision
);

  import shared_mem_pkg::req_t;
  import shared_mem_pkg::OP_READ;
  import shared_mem_pkg::OP_WRITE;

  logic              pci_busy;
  logic              pci_rd_ok;
  logic              pci_is_flag;
  logic              fpga_is_flag;
  logic              issue;
  logic              fpga_rd_issue;
  logic              fpga_wr_issue;
  req_t              entry;
  logic [DATA_W-1:0] flag_q;

  logic              pci_s1_vld;
  logic              pci_s1_flag;
  logic [DATA_W-1:0] pci_s1_fval;
  logic              fpga_s1_vld;
  logic              fpga_s1_flag;
  logic [DATA_W-1:0] fpga_s1_fval;

  fpga_req_buffer u_req_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_req   (rd_req),
    .wr_req   (fpga_wr_en),
    .req_addr (req_addr),
    .req_data (write_data),
    .stall    (pci_busy),
    .issue    (issue),
    .entry    (entry),
    .overflow (req_overflow)
  );

  always_comb begin
    pci_busy      = pci_wr_en | pci_rd_en;
    pci_rd_ok     = pci_rd_en & ~pci_wr_en;
    pci_is_flag   = (pci_req_addr == FLAG_ADDR);
    fpga_is_flag  = (entry.addr == FLAG_ADDR);
    fpga_rd_issue = issue && (entry.op == OP_READ);
    fpga_wr_issue = issue && (entry.op == OP_WRITE);
  end

  // SRAM port mux; held quiet while in reset regardless of host strobes
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      if (pci_busy) begin
        mem_addr  = pci_req_addr;
        mem_wdata = pci_input_data;
        mem_en    = !pci_is_flag;
        mem_we    = pci_wr_en && !pci_is_flag;
      end else if (issue) begin
        mem_addr  = entry.addr;
        mem_wdata = entry.data;
        mem_en    = !fpga_is_flag;
        mem_we    = fpga_wr_issue && !fpga_is_flag;
      end
    end
  end

  // Host write beats the direct flag strobe, which beats a queued FPGA write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= '0;
    end else if (pci_wr_en && pci_is_flag) begin
      flag_q <= pci_input_data;
    end else if (flag_we) begin
      flag_q <= out_flag;
    end else if (fpga_wr_issue && fpga_is_flag) begin
      flag_q <= entry.data;
    end
  end

  assign in_flag = flag_q;

  // Flag reads travel alongside the SRAM pipeline so both latencies match
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pci_s1_vld    <= 1'b0;
      pci_s1_flag   <= 1'b0;
      pci_s1_fval   <= '0;
      fpga_s1_vld   <= 1'b0;
      fpga_s1_flag  <= 1'b0;
      fpga_s1_fval  <= '0;
      pci_rd_valid  <= 1'b0;
      pci_rd_data   <= '0;
      rd_ready      <= 1'b0;
      rd_data       <= '0;
      pci_collision <= 1'b0;
    end else begin
      pci_s1_vld   <= pci_rd_ok;
      pci_s1_flag  <= pci_is_flag;
      pci_s1_fval  <= flag_q;
      fpga_s1_vld  <= fpga_rd_issue;
      fpga_s1_flag <= fpga_is_flag;
      fpga_s1_fval <= flag_q;

      pci_rd_valid <= pci_s1_vld;
      if (pci_s1_vld) pci_rd_data <= pci_s1_flag ? pci_s1_fval : mem_rdata;

      rd_ready <= fpga_s1_vld;
      if (fpga_s1_vld) rd_data <= fpga_s1_flag ? fpga_s1_fval : mem_rdata;

      if (pci_wr_en && pci_rd_en) pci_collision <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Bench for shared_mem_responder: SRAM model, latency-based reference model
// checked every cycle, directed scenarios with literal checks, random traffic.
module tb_shared_mem_responder;

  localparam int AW = 21;
  localparam int DW = 32;
  localparam logic [AW-1:0] FLAG = 21'h07FFFE;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pci_wr_en, pci_rd_en;
  logic [AW-1:0] pci_req_addr;
  logic [DW-1:0] pci_input_data;
  logic [DW-1:0] pci_rd_data;
  logic          pci_rd_valid;
  logic          rd_req, fpga_wr_en;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic          flag_we;
  logic [DW-1:0] out_flag;
  logic [DW-1:0] in_flag;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          req_overflow, pci_collision;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  shared_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .FLAG_ADDR(FLAG)) dut (
    .clk(clk), .rst_n(rst_n),
    .pci_wr_en(pci_wr_en), .pci_rd_en(pci_rd_en), .pci_req_addr(pci_req_addr),
    .pci_input_data(pci_input_data), .pci_rd_data(pci_rd_data), .pci_rd_valid(pci_rd_valid),
    .rd_req(rd_req), .fpga_wr_en(fpga_wr_en), .req_addr(req_addr), .write_data(write_data),
    .rd_data(rd_data), .rd_ready(rd_ready),
    .flag_we(flag_we), .out_flag(out_flag), .in_flag(in_flag),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .req_overflow(req_overflow), .pci_collision(pci_collision)
  );

  function automatic logic [DW-1:0] preload(input logic [AW-1:0] a);
    return {11'h5A5, a};
  endfunction

  // Synchronous single-port SRAM, contents survive responder reset
  logic [DW-1:0] sram [logic [AW-1:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) sram[mem_addr] = mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= sram.exists(mem_addr) ? sram[mem_addr] : preload(mem_addr);
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: storage, flag, pending slot, and scheduled read returns
  typedef struct { int due; logic [DW-1:0] data; } due_t;
  due_t          pq[$];
  due_t          fq[$];
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  logic [DW-1:0] m_flag = '0, m_pci_data = '0, m_rd_data = '0;
  bit            m_ovf = 0, m_col = 0, m_pv = 0, m_pop = 0;
  logic [AW-1:0] m_pa = '0;
  logic [DW-1:0] m_pd = '0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    if (a == FLAG) return m_flag;
    return ref_mem.exists(a) ? ref_mem[a] : preload(a);
  endfunction

  always @(negedge clk) begin
    bit busy, iss, ev_p, ev_f, e_en, e_we, req;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, nflag;
    if (!rst_n) begin
      pq.delete(); fq.delete();
      m_flag = '0; m_pci_data = '0; m_rd_data = '0;
      m_ovf = 0; m_col = 0; m_pv = 0;
      chk("rst_pci_rd_valid", {31'b0, pci_rd_valid}, 0);
      chk("rst_pci_rd_data", pci_rd_data, 0);
      chk("rst_rd_ready", {31'b0, rd_ready}, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_in_flag", in_flag, 0);
      chk("rst_mem_en", {31'b0, mem_en}, 0);
      chk("rst_mem_we", {31'b0, mem_we}, 0);
      chk("rst_req_overflow", {31'b0, req_overflow}, 0);
      chk("rst_pci_collision", {31'b0, pci_collision}, 0);
    end else begin
      busy = pci_wr_en || pci_rd_en;
      iss  = m_pv && !busy;
      ev_p = (pq.size() > 0) && (pq[0].due == cyc);
      ev_f = (fq.size() > 0) && (fq[0].due == cyc);
      if (ev_p) begin m_pci_data = pq[0].data; void'(pq.pop_front()); end
      if (ev_f) begin m_rd_data = fq[0].data; void'(fq.pop_front()); end
      chk("pci_rd_valid", {31'b0, pci_rd_valid}, {31'b0, ev_p});
      chk("pci_rd_data", pci_rd_data, m_pci_data);
      chk("rd_ready", {31'b0, rd_ready}, {31'b0, ev_f});
      chk("rd_data", rd_data, m_rd_data);
      chk("in_flag", in_flag, m_flag);
      chk("req_overflow", {31'b0, req_overflow}, {31'b0, m_ovf});
      chk("pci_collision", {31'b0, pci_collision}, {31'b0, m_col});

      e_en = 0; e_we = 0; e_addr = '0; e_wd = '0;
      if (busy) begin
        e_en = (pci_req_addr != FLAG); e_we = e_en && pci_wr_en;
        e_addr = pci_req_addr; e_wd = pci_input_data;
      end else if (iss) begin
        e_en = (m_pa != FLAG); e_we = e_en && m_pop;
        e_addr = m_pa; e_wd = m_pd;
      end
      chk("mem_en", {31'b0, mem_en}, {31'b0, e_en});
      chk("mem_we", {31'b0, mem_we}, {31'b0, e_we});
      if (e_en) chk("mem_addr", {11'b0, mem_addr}, {11'b0, e_addr});
      if (e_we) chk("mem_wdata", mem_wdata, e_wd);

      if (pci_rd_en && !pci_wr_en) pq.push_back('{cyc + 2, ref_rd(pci_req_addr)});
      if (iss && !m_pop) fq.push_back('{cyc + 2, ref_rd(m_pa)});
      if (pci_wr_en && pci_req_addr != FLAG) ref_mem[pci_req_addr] = pci_input_data;
      if (iss && m_pop && m_pa != FLAG) ref_mem[m_pa] = m_pd;
      nflag = m_flag;
      if (iss && m_pop && m_pa == FLAG) nflag = m_pd;
      if (flag_we) nflag = out_flag;
      if (pci_wr_en && pci_req_addr == FLAG) nflag = pci_input_data;
      m_flag = nflag;
      if (pci_wr_en && pci_rd_en) m_col = 1;
      req = rd_req || fpga_wr_en;
      if (rd_req && fpga_wr_en) m_ovf = 1;
      if (iss) m_pv = 0;
      if (req) begin
        if (!m_pv) begin
          m_pv = 1; m_pop = fpga_wr_en; m_pa = req_addr; m_pd = write_data;
        end else m_ovf = 1;
      end
    end
    cyc++;
  end

  task automatic clr();
    pci_wr_en = 0; pci_rd_en = 0; pci_req_addr = '0; pci_input_data = '0;
    rd_req = 0; fpga_wr_en = 0; req_addr = '0; write_data = '0;
    flag_we = 0; out_flag = '0;
  endtask

  task automatic nxt(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 15) == 0) return FLAG;
    return AW'($urandom_range(0, 15));
  endfunction

  int cnt;

  initial begin
    clr();
    rst_n = 0;
    nxt(3);
    rst_n = 1;
    nxt();
    @(negedge clk);
    chk("lit_reset_in_flag", in_flag, 32'h0);
    chk("lit_reset_overflow", {31'b0, req_overflow}, 0);
    nxt();

    // Host write then host read of the same word
    pci_wr_en = 1; pci_req_addr = 21'h10; pci_input_data = 32'hDEADBEEF;
    nxt();
    clr(); pci_rd_en = 1; pci_req_addr = 21'h10;
    nxt();
    clr();
    @(negedge clk); chk("lit_pci_rd_early", {31'b0, pci_rd_valid}, 0);
    nxt();
    @(negedge clk);
    chk("lit_pci_rd_valid", {31'b0, pci_rd_valid}, 1);
    chk("lit_pci_rd_data", pci_rd_data, 32'hDEADBEEF);
    nxt();

    // FPGA read, idle host port
    rd_req = 1; req_addr = 21'h10;
    nxt();
    clr();
    nxt();
    @(negedge clk); chk("lit_fpga_rd_early", {31'b0, rd_ready}, 0);
    nxt();
    @(negedge clk);
    chk("lit_fpga_rd_ready", {31'b0, rd_ready}, 1);
    chk("lit_fpga_rd_data", rd_data, 32'hDEADBEEF);
    nxt();
    @(negedge clk); chk("lit_fpga_rd_pulse", {31'b0, rd_ready}, 0);
    nxt();

    // FPGA read stalled by two host writes
    rd_req = 1; req_addr = 21'h11;
    nxt();
    clr(); pci_wr_en = 1; pci_req_addr = 21'h20; pci_input_data = 32'h1;
    @(negedge clk); chk("lit_stall_mem_addr", {11'b0, mem_addr}, 32'h20);
    nxt();
    pci_req_addr = 21'h21; pci_input_data = 32'h2;
    nxt();
    clr();
    @(negedge clk); chk("lit_stall_issue_addr", {11'b0, mem_addr}, 32'h11);
    nxt();
    @(negedge clk); chk("lit_stall_rd_early", {31'b0, rd_ready}, 0);
    nxt();
    @(negedge clk);
    chk("lit_stall_rd_ready", {31'b0, rd_ready}, 1);
    chk("lit_stall_rd_data", rd_data, 32'hB4A00011);
    nxt();

    // Flag register
    pci_wr_en = 1; pci_req_addr = FLAG; pci_input_data = 32'h0001_0000;
    nxt();
    clr();
    @(negedge clk); chk("lit_flag_pci", in_flag, 32'h0001_0000);
    nxt();
    flag_we = 1; out_flag = 32'h2;
    pci_wr_en = 1; pci_req_addr = FLAG; pci_input_data = 32'h5;
    nxt();
    clr();
    @(negedge clk); chk("lit_flag_pci_wins", in_flag, 32'h5);
    nxt();

    // Two FPGA requests against a continuously busy host port
    pci_rd_en = 1; pci_req_addr = 21'h30; rd_req = 1; req_addr = 21'h12;
    nxt();
    pci_req_addr = 21'h31; req_addr = 21'h13;
    nxt();
    rd_req = 0; pci_req_addr = 21'h32;
    @(negedge clk); chk("lit_overflow_set", {31'b0, req_overflow}, 1);
    nxt();
    pci_req_addr = 21'h33;
    nxt();
    clr();
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); cnt += int'(rd_ready);
      nxt();
    end
    chk("lit_overflow_one_ready", cnt, 1);
    chk("lit_overflow_sticky", {31'b0, req_overflow}, 1);

    // Reset one cycle after an FPGA read
    rd_req = 1; req_addr = 21'h14;
    nxt();
    clr(); rst_n = 0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); cnt += int'(rd_ready);
      nxt();
      if (i == 1) rst_n = 1;
    end
    chk("lit_reset_no_ready", cnt, 0);
    @(negedge clk);
    chk("lit_reset_flag_clear", in_flag, 32'h0);
    chk("lit_reset_ovf_clear", {31'b0, req_overflow}, 0);
    nxt();

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      pci_wr_en      = (r < 20);
      pci_rd_en      = (r >= 18 && r < 40);
      pci_req_addr   = rnd_addr();
      pci_input_data = $urandom;
      rd_req         = ($urandom_range(0, 99) < 35);
      fpga_wr_en     = ($urandom_range(0, 99) < 25);
      req_addr       = rnd_addr();
      write_data     = $urandom;
      flag_we        = ($urandom_range(0, 99) < 8);
      out_flag       = $urandom;
      rst_n          = ($urandom_range(0, 999) != 0);
      nxt();
    end
    clr();
    rst_n = 1;
    nxt(4);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
